param_score_board: RTL
======================

PARAM_SCORE_BOARD -- requirements
Module: param_score_board

Interface
REQ-001 Parameters SHALL be: NREG 32, number of architectural registers (power of 2); ISSUE 2, write/issue slots per cycle; RPORTS 4, read ports; DEPTH 3, position-vector width (one bit per tracked pipeline stage).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 stall  in  1  global pipeline stall; freezes all state except long-latency completion.
REQ-005 flush  in  1  pipeline flush; clears state.
REQ-006 stage_stall  in  DEPTH  per-stage stall mask; bit k high = stage k holding.
REQ-007 wr_en  in  ISSUE  per-slot allocate request.
REQ-008 wr_addr  in  ISSUE x log2(NREG)  destination register per slot.
REQ-009 wr_pos  in  ISSUE x DEPTH  initial position vector per slot.
REQ-010 wr_ll  in  ISSUE  slot's producer is long-latency (mul/div).
REQ-011 ll_done  in  1  long-latency unit completion strobe.
REQ-012 ll_addr  in  log2(NREG)  register completed by ll_done.
REQ-013 rd_addr  in  RPORTS x log2(NREG)  lookup addresses.
REQ-014 rd_pos  out  RPORTS x DEPTH  position vector of addressed entry.
REQ-015 rd_ll  out  RPORTS  long-latency pending flag of addressed entry.
REQ-016 rd_busy  out  RPORTS  rd_pos nonzero or rd_ll set.
REQ-017 busy_count  out  log2(NREG)+1  registered count of busy entries.

Function
REQ-018 Each entry SHALL hold pos[DEPTH-1:0] and ll (1 bit); entry 0 SHALL never be written and SHALL always read pos=0, ll=0.
REQ-019 Read outputs SHALL be combinational from current state; same-cycle writes SHALL NOT bypass to reads.
REQ-020 When stall=0, each non-written entry SHALL shift pos right by one iff (pos & stage_stall)==0, else hold.
REQ-021 Entries with ll=1 SHALL NOT shift pos; pos holds until ll clears.
REQ-022 When stall=0 and wr_en[s]=1 with wr_addr[s]!=0, entry SHALL load pos=wr_pos[s], ll=wr_ll[s].
REQ-023 Multiple slots writing the same address: highest-numbered slot SHALL win.
REQ-024 ll_done SHALL clear ll of entry ll_addr even when stall=1; pos of that entry SHALL then resume shifting next cycle.
REQ-025 ll_done and an accepted write to the same address in one cycle: write SHALL win (ll=wr_ll).
REQ-026 ll_done to an entry with ll=0 SHALL have no effect.
REQ-027 flush SHALL clear pos and ll of all entries next cycle, overriding writes, shifts and ll_done.
REQ-028 stall=1 SHALL ignore wr_en and suppress shifting.
REQ-029 busy_count SHALL equal the number of entries with pos!=0 or ll=1 in the state one cycle earlier (one-cycle latency, registered), saturating never needed (max NREG-1).
REQ-030 All position arithmetic SHALL be DEPTH bits wide; bit 0 shifting out is discarded, zero shifts in at MSB.

Reset
REQ-031 rst SHALL clear all pos and ll to 0 and busy_count to 0; rst SHALL take priority over flush, stall and writes.
REQ-032 After rst deassertion, rd_pos=0, rd_ll=0, rd_busy=0 on all ports until first accepted write.

Structure
REQ-033 Entry struct typedef (pos, ll) and DEPTH/NREG defaults SHALL live in the shared defines package.
REQ-034 Per-entry next-state logic SHALL be one sub-module, score_entry, instantiated NREG-1 times; top holds write arbitration, read muxes and busy counter.
REQ-035 No latches; single clock domain.

Verification
REQ-036 rst, write slot0 r5 pos=100, no stall -> rd_pos(r5) 100, 010, 001, 000 on successive cycles; busy_count 1,1,1,0 lagging one cycle.
REQ-037 Both slots write r7 (slot0 pos=100, slot1 pos=010) -> rd_pos(r7)=010.
REQ-038 r3 at pos=010, stage_stall=010 for 2 cycles -> r3 holds 010 two cycles; r4 at 100 same time shifts to 010.
REQ-039 Write r9 pos=010 wr_ll=1, hold 5 cycles with stall=1 on cycle 3, ll_done r9 on cycle 3 -> ll clears despite stall, pos then 001, 000.
REQ-040 ll_done r9 and slot1 write r9 pos=100 ll=0 same cycle -> r9 pos=100, ll=0.
REQ-041 Entries busy, flush=1 with concurrent write r2 -> all rd_busy 0 next cycle, r2 not written; write to r0 -> rd_pos(r0)=0.

Source files
------------

// File: rtl/param_score_board_pkg.sv
// Shared definitions for the register scoreboard.
//   SB_*        : default geometry (registers, issue slots, read ports, stages)
//   sb_entry_t  : per-register scoreboard state (stage position vector + long-latency pending)
//   sb_busy()   : an entry is busy while its position is nonzero or a long-latency result is owed
package param_score_board_pkg;
  localparam int SB_NREG   = 32;
  localparam int SB_ISSUE  = 2;
  localparam int SB_RPORTS = 4;
  localparam int SB_DEPTH  = 3;

  typedef struct packed {
    logic [SB_DEPTH-1:0] pos;
    logic                ll;
  } sb_entry_t;

  function automatic logic sb_busy(sb_entry_t e);
    return (|e.pos) | e.ll;
  endfunction
endpackage

// File: rtl/param_score_board_if.sv
// Scoreboard bus: pipeline control, issue-slot writes, long-latency completion,
// read lookups and the busy counter.
//   master : pipeline side (drives control/writes/lookups, receives lookup results)
//   slave  : scoreboard side
interface param_score_board_if #(
  parameter int NREG   = 32,
  parameter int ISSUE  = 2,
  parameter int RPORTS = 4,
  parameter int DEPTH  = 3
);
  localparam int AW = $clog2(NREG);

  logic                          stall;
  logic                          flush;
  logic [DEPTH-1:0]              stage_stall;
  logic [ISSUE-1:0]              wr_en;
  logic [ISSUE-1:0][AW-1:0]      wr_addr;
  logic [ISSUE-1:0][DEPTH-1:0]   wr_pos;
  logic [ISSUE-1:0]              wr_ll;
  logic                          ll_done;
  logic [AW-1:0]                 ll_addr;
  logic [RPORTS-1:0][AW-1:0]     rd_addr;
  logic [RPORTS-1:0][DEPTH-1:0]  rd_pos;
  logic [RPORTS-1:0]             rd_ll;
  logic [RPORTS-1:0]             rd_busy;
  logic [AW:0]                   busy_count;

  modport master (
    output stall, flush, stage_stall, wr_en, wr_addr, wr_pos, wr_ll, ll_done, ll_addr, rd_addr,
    input  rd_pos, rd_ll, rd_busy, busy_count
  );
  modport slave (
    input  stall, flush, stage_stall, wr_en, wr_addr, wr_pos, wr_ll, ll_done, ll_addr, rd_addr,
    output rd_pos, rd_ll, rd_busy, busy_count
  );
endinterface

// File: rtl/param_score_board_entry.sv
// score_entry: next-state logic and storage for one scoreboard register.
//   clk, rst     : clock, synchronous active-high reset
//   flush        : clear entry (beats everything but rst)
//   stall        : global stall, blocks writes and shifting
//   stage_stall  : per-stage hold mask
//   we/wpos/wll  : arbitrated write already qualified with !stall
//   ll_clr       : long-latency completion addressed to this entry
//   ent_q        : current entry state
module score_entry
  import param_score_board_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                stall,
  input  logic [SB_DEPTH-1:0] stage_stall,
  input  logic                we,
  input  logic [SB_DEPTH-1:0] wpos,
  input  logic                wll,
  input  logic                ll_clr,
  output sb_entry_t           ent_q
);
  sb_entry_t ent_d;

  always_comb begin
    ent_d = ent_q;
    if (flush) begin
      ent_d = '0;
    end else begin
      // completion is honoured through a stall; pos still uses the old ll,
      // so shifting resumes the cycle after ll drops
      if (ll_clr) ent_d.ll = 1'b0;
      if (!stall) begin
        if (we) begin
          ent_d.pos = wpos;
          ent_d.ll  = wll;
        end else if (!ent_q.ll && ((ent_q.pos & stage_stall) == '0)) begin
          ent_d.pos = ent_q.pos >> 1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ent_q <= '0;
    else     ent_q <= ent_d;
  end
endmodule

// File: rtl/param_score_board.sv
// param_score_board: register scoreboard tracking in-flight producers by pipeline stage.
//   clk, rst : clock, synchronous active-high reset
//   sb       : scoreboard bus (slave) -- control, writes, ll completion, lookups, busy_count
// Holds write arbitration (highest slot wins), combinational read muxes (no
// write bypass) and the registered busy counter. Entry 0 is hardwired to zero.
// DEPTH must equal SB_DEPTH since the entry struct is sized from the package.
module param_score_board
  import param_score_board_pkg::*;
#(
  parameter int NREG   = SB_NREG,
  parameter int ISSUE  = SB_ISSUE,
  parameter int RPORTS = SB_RPORTS,
  parameter int DEPTH  = SB_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  param_score_board_if.slave    sb
);
  localparam int AW = $clog2(NREG);

  logic [NREG-1:0][DEPTH-1:0] pos_a;
  logic [NREG-1:0]            ll_a;
  logic [NREG-1:1]            we;
  logic [NREG-1:1][DEPTH-1:0] wpos;
  logic [NREG-1:1]            wll;
  logic [AW:0]                busy_count_d, busy_count_q;

  // later slots overwrite earlier ones, so the highest-numbered slot wins
  always_comb begin
    we   = '0;
    wpos = '0;
    wll  = '0;
    for (int i = 1; i < NREG; i++) begin
      for (int s = 0; s < ISSUE; s++) begin
        if (sb.wr_en[s] && (sb.wr_addr[s] == AW'(i))) begin
          we[i]   = !sb.stall;
          wpos[i] = sb.wr_pos[s];
          wll[i]  = sb.wr_ll[s];
        end
      end
    end
  end

  assign pos_a[0] = '0;
  assign ll_a[0]  = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_ent
    sb_entry_t e;
    score_entry u_ent (
      .clk         (clk),
      .rst         (rst),
      .flush       (sb.flush),
      .stall       (sb.stall),
      .stage_stall (sb.stage_stall),
      .we          (we[i]),
      .wpos        (wpos[i]),
      .wll         (wll[i]),
      .ll_clr      (sb.ll_done && (sb.ll_addr == AW'(i))),
      .ent_q       (e)
    );
    assign pos_a[i] = e.pos;
    assign ll_a[i]  = e.ll;
  end

  always_comb begin
    for (int p = 0; p < RPORTS; p++) begin
      sb.rd_pos[p]  = pos_a[sb.rd_addr[p]];
      sb.rd_ll[p]   = ll_a[sb.rd_addr[p]];
      sb.rd_busy[p] = (|pos_a[sb.rd_addr[p]]) | ll_a[sb.rd_addr[p]];
    end
  end

  always_comb begin
    busy_count_d = '0;
    for (int i = 1; i < NREG; i++)
      busy_count_d = busy_count_d + (AW+1)'((|pos_a[i]) | ll_a[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) busy_count_q <= '0;
    else     busy_count_q <= busy_count_d;
  end

  assign sb.busy_count = busy_count_q;
endmodule
